// File: rtl/guia_0511_if.sv
// Operand/result stream bundle for guia_0511: operands and op in, registered result out.
// master drives operands and accepts results; slave is the logic unit.
interface guia_0511_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             out_par;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, s, out_par
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, s, out_par
    );
endinterface

// File: rtl/guia_0511.sv
// WIDTH-bit two-operand logic unit (8 functions incl. IMPLY) with a hardware truth-table sweep
// folding all results into a SIGW-bit signature. Stream latency 1, full throughput; in_ready
// drops under output backpressure and outside IDLE. Optional parity: GUIA_0511_OUT_PARITY_EN.
module guia_0511 #(
    parameter int WIDTH = 4,
    parameter int SIGW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    guia_0511_if.slave      bus,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [SIGW-1:0] sig
);
    localparam int CW = 14;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << (2 * WIDTH)) - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_lat;
    logic [WIDTH-1:0] s_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             done_q;
    logic [SIGW-1:0]  sig_q;
    logic             in_ready_int;
    logic             accept;
    logic [WIDTH-1:0] stream_res;
    logic [WIDTH-1:0] sweep_res;
    logic [WIDTH-1:0] sweep_a;
    logic [WIDTH-1:0] sweep_b;

    function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0] f,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        case (f)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return ~(x & y);
            3'b011:  return ~(x | y);
            3'b100:  return x ^ y;
            3'b101:  return ~(x ^ y);
            3'b110:  return ~x | y;
            default: return x & ~y;
        endcase
    endfunction

    // A start request in IDLE takes priority over a concurrent operand beat.
    assign in_ready_int = rst_n && (state == IDLE) && !start && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && in_ready_int;
    assign stream_res   = logic_fn(bus.op, bus.a, bus.b);
    assign sweep_a      = cnt[2*WIDTH-1:WIDTH];
    assign sweep_b      = cnt[WIDTH-1:0];
    assign sweep_res    = logic_fn(op_lat, sweep_a, sweep_b);

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign sig           = sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_lat      <= '0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sig_q       <= '0;
        end else begin
            done_q <= 1'b0;
            // The output stage drains independently of the FSM state.
            if (accept) begin
                s_q         <= stream_res;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SWEEP;
                        op_lat <= bus.op;
                        sig_q  <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SWEEP: begin
                    sig_q <= {sig_q[SIGW-2:0], sig_q[SIGW-1]} ^ SIGW'(sweep_res);
                    if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GUIA_0511_OUT_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^stream_res;
        end
    end

    assign bus.out_par = par_q;
`else
    assign bus.out_par = 1'b0;
`endif
endmodule

// File: tb/tb_guia_0511.sv
// Bench for guia_0511: directed op table, backpressure, random stream vs. scoreboard,
// sweeps against an arithmetic signature model (WIDTH=4 and WIDTH=1 instances).
module tb_guia_0511;
    logic        clk = 1'b0;
    logic        rst_n, rst1_n;
    logic        start, start1;
    logic        busy, done, busy1, done1;
    logic [15:0] sig, sig1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    guia_0511_if #(.WIDTH(4)) bus ();
    guia_0511_if #(.WIDTH(1)) bus1 ();

    guia_0511 #(.WIDTH(4), .SIGW(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .start(start), .busy(busy), .done(done), .sig(sig)
    );

    guia_0511 #(.WIDTH(1), .SIGW(16)) dut1 (
        .clk(clk), .rst_n(rst1_n), .bus(bus1.slave),
        .start(start1), .busy(busy1), .done(done1), .sig(sig1)
    );

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] s;
    } vec_t;

    vec_t vec [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Truth table of each function indexed by {a_bit, b_bit}.
    function automatic logic [3:0] truth(input int f);
        case (f)
            0: return 4'b1000;
            1: return 4'b1110;
            2: return 4'b0111;
            3: return 4'b0001;
            4: return 4'b0110;
            5: return 4'b1001;
            6: return 4'b1011;
            default: return 4'b0100;
        endcase
    endfunction

    function automatic int ref_fn(input int f, input int x, input int y, input int w);
        logic [3:0] tt;
        int r;
        tt = truth(f);
        r = 0;
        for (int i = 0; i < w; i++) begin
            if (tt[((x >> i) & 1) * 2 + ((y >> i) & 1)]) r |= (1 << i);
        end
        return r;
    endfunction

    function automatic int ref_sig(input int f, input int w);
        int acc;
        int mask;
        acc = 0;
        mask = (1 << w) - 1;
        for (int c = 0; c < (1 << (2 * w)); c++) begin
            acc = (((acc << 1) | (acc >> 15)) & 32'hFFFF) ^ ref_fn(f, c >> w, c & mask, w);
        end
        return acc;
    endfunction

    function automatic int par_of(input int v);
`ifdef GUIA_0511_OUT_PARITY_EN
        logic [3:0] t;
        t = v[3:0];
        return int'(^t);
`else
        return 0;
`endif
    endfunction

    task automatic wait_sweep4(input int already, input int exp_sig, input string name);
        int n;
        n = already;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_cycles"}, n, 256);
        chk({name, "_done"}, int'(done), 1);
        chk({name, "_busy_at_done"}, int'(busy), 0);
        chk({name, "_sig"}, int'(sig), exp_sig);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_done_one_cycle"}, int'(done), 0);
        chk({name, "_start_in_done_ignored"}, int'(busy), 0);
    endtask

    initial begin
        int q[$];
        int exp_v, n, rop;
        logic acc, drn, saw_done;

        vec[0] = '{3'b000, 4'b1100, 4'b1010, 4'b1000};
        vec[1] = '{3'b001, 4'b1100, 4'b1010, 4'b1110};
        vec[2] = '{3'b010, 4'b1100, 4'b1010, 4'b0111};
        vec[3] = '{3'b011, 4'b1100, 4'b1010, 4'b0001};
        vec[4] = '{3'b100, 4'b0110, 4'b0011, 4'b0101};
        vec[5] = '{3'b101, 4'b0110, 4'b0011, 4'b1010};
        vec[6] = '{3'b110, 4'b0101, 4'b0011, 4'b1011};
        vec[7] = '{3'b111, 4'b0101, 4'b0011, 4'b0100};

        rst_n = 1'b0; rst1_n = 1'b0; start = 1'b0; start1 = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.op = '0; bus1.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_s", int'(bus.s), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sig", int'(sig), 0);
        chk("rst_out_par", int'(bus.out_par), 0);
        chk("rst1_in_ready", int'(bus1.in_ready), 0);

        rst_n = 1'b1; rst1_n = 1'b1;
        #1 chk("post_rst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);

        // All eight functions, back to back.
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1; bus.op = vec[i].op; bus.a = vec[i].a; bus.b = vec[i].b;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), int'(bus.out_valid), 1);
            chk($sformatf("tbl%0d_s", i), int'(bus.s), int'(vec[i].s));
            chk($sformatf("tbl%0d_par", i), int'(bus.out_par), par_of(int'(vec[i].s)));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("tbl_drained", int'(bus.out_valid), 0);

        // Backpressure holds the result for three cycles.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.op = 3'b000; bus.a = 4'b1111; bus.b = 4'b1010;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_s", int'(bus.s), 4'b1010);
            chk("bp_valid", int'(bus.out_valid), 1);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_release_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        chk("bp_drained", int'(bus.out_valid), 0);

        // Random stream against a one-deep scoreboard.
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a = 4'($urandom); bus.b = 4'($urandom); bus.op = 3'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = bus.in_valid && bus.in_ready;
            drn = bus.out_valid && bus.out_ready;
            chk("rnd_valid", int'(bus.out_valid), (q.size() != 0) ? 1 : 0);
            if (drn && q.size() != 0) begin
                exp_v = q.pop_front();
                chk("rnd_s", int'(bus.s), exp_v);
                chk("rnd_par", int'(bus.out_par), par_of(exp_v));
            end
            if (acc) q.push_back(ref_fn(int'(bus.op), int'(bus.a), int'(bus.b), 4));
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Sweep wins over a concurrent beat.
        rop = $urandom_range(0, 7);
        bus.in_valid = 1'b1; bus.op = 3'(rop); start = 1'b1;
        #1 chk("start_wins_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        start = 1'b0; bus.in_valid = 1'b0;
        chk("start_beat_dropped", int'(bus.out_valid), 0);
        chk("sweep_busy", int'(busy), 1);
        wait_sweep4(0, ref_sig(rop, 4), "sweep_rnd");

        // A pending result survives the start of a sweep and drains during it.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.op = 3'b100; bus.a = 4'b0110; bus.b = 4'b0011;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.op = 3'b110; start = 1'b1;
        @(negedge clk);
        start = 1'b0; bus.op = 3'b000;
        chk("pend_busy", int'(busy), 1);
        chk("pend_s", int'(bus.s), 4'b0101);
        chk("pend_valid", int'(bus.out_valid), 1);
        chk("pend_in_ready", int'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("pend_drained", int'(bus.out_valid), 0);
        wait_sweep4(1, ref_sig(6, 4), "sweep_imply4");

        // WIDTH=1 IMPLY sweep: results 1,1,0,1.
        bus1.op = 3'b110; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (busy1 && n < 100) begin n++; @(negedge clk); end
        chk("w1_cycles", n, 4);
        chk("w1_done", int'(done1), 1);
        chk("w1_sig", int'(sig1), 16'h000D);

        // Reset in the middle of a sweep, then repeat it.
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        rst1_n = 1'b0;
        #1;
        chk("w1_abort_sig", int'(sig1), 0);
        chk("w1_abort_busy", int'(busy1), 0);
        @(negedge clk);
        rst1_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (done1) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("w1_abort_no_done", int'(saw_done), 0);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (busy1 && n < 100) begin n++; @(negedge clk); end
        chk("w1_resweep_cycles", n, 4);
        chk("w1_resweep_sig", int'(sig1), 16'h000D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
